// File: rtl/draw_engine.sv
// Frame-buffer draw engine: turns write/read/fill-rect commands into a stream of
// single-pixel requests on the memory handshake, clipping against the visible screen.
module draw_engine #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [1:0] cmdOp,
    input  logic [8:0] cmdX,
    input  logic [7:0] cmdY,
    input  logic [8:0] cmdWidth,
    input  logic [7:0] cmdHeight,
    input  logic [7:0] cmdColor,
    output logic [7:0] readData,
    output logic       readDataValid,
    output logic       busy,
    output logic [8:0] memoryXCoord,
    output logic [7:0] memoryYCoord,
    output logic       memoryWriteRequest,
    output logic       memoryReadRequest,
    output logic [7:0] memoryWriteData,
    input  logic [7:0] memoryReadData,
    input  logic       memoryWriteComplete,
    input  logic       memoryReadComplete
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        STEP,
        RESPOND
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;

    state_t      stateReg, stateNext;
    logic [8:0]  xStartReg;
    logic [8:0]  xReg;
    logic [7:0]  yReg;
    logic [9:0]  xEndReg;
    logic [8:0]  yEndReg;
    logic [7:0]  colorReg;
    logic [7:0]  readDataReg;

    logic        accept;
    logic        clipped;
    logic [9:0]  xRoom;
    logic [8:0]  yRoom;
    logic [9:0]  reqWidth;
    logic [8:0]  reqHeight;
    logic [9:0]  effWidth;
    logic [8:0]  effHeight;
    logic        zeroSize;
    logic        rowDone;
    logic        lastPixel;

    assign cmdReady = (stateReg == IDLE) && !reset;
    assign accept   = cmdValid && cmdReady;

    // Clip arithmetic is one bit wider than the coordinates so sums never wrap.
    assign clipped   = ({1'b0, cmdX} >= 10'(SCREEN_WIDTH)) || ({1'b0, cmdY} >= 9'(SCREEN_HEIGHT));
    assign xRoom     = 10'(SCREEN_WIDTH) - {1'b0, cmdX};
    assign yRoom     = 9'(SCREEN_HEIGHT) - {1'b0, cmdY};
    assign reqWidth  = (cmdOp == OP_FILL) ? {1'b0, cmdWidth}  : 10'd1;
    assign reqHeight = (cmdOp == OP_FILL) ? {1'b0, cmdHeight} : 9'd1;
    assign effWidth  = clipped ? 10'd0 : ((reqWidth < xRoom) ? reqWidth : xRoom);
    assign effHeight = clipped ? 9'd0 : ((reqHeight < yRoom) ? reqHeight : yRoom);
    assign zeroSize  = (effWidth == 10'd0) || (effHeight == 9'd0);

    assign rowDone   = ({1'b0, xReg} + 10'd1) >= xEndReg;
    assign lastPixel = rowDone && (({1'b0, yReg} + 9'd1) >= yEndReg);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    case (cmdOp)
                        OP_WRITE, OP_FILL: stateNext = zeroSize ? IDLE : WRITE;
                        OP_READ:           stateNext = clipped ? RESPOND : READ;
                        default:           stateNext = IDLE;
                    endcase
                end
            end
            WRITE:   if (memoryWriteComplete) stateNext = STEP;
            READ:    if (memoryReadComplete)  stateNext = RESPOND;
            STEP:    stateNext = lastPixel ? IDLE : WRITE;
            RESPOND: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg    <= IDLE;
            xStartReg   <= '0;
            xReg        <= '0;
            yReg        <= '0;
            xEndReg     <= '0;
            yEndReg     <= '0;
            colorReg    <= '0;
            readDataReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                xStartReg <= cmdX;
                xReg      <= cmdX;
                yReg      <= cmdY;
                xEndReg   <= {1'b0, cmdX} + effWidth;
                yEndReg   <= {1'b0, cmdY} + effHeight;
                colorReg  <= cmdColor;
                if (cmdOp == OP_READ && clipped) begin
                    readDataReg <= '0;
                end
            end
            if (stateReg == READ && memoryReadComplete) begin
                readDataReg <= memoryReadData;
            end
            // Raster advance: wrap to the start column and move down a row.
            if (stateReg == STEP) begin
                if (!rowDone) begin
                    xReg <= xReg + 9'd1;
                end else begin
                    xReg <= xStartReg;
                    yReg <= yReg + 8'd1;
                end
            end
        end
    end

    assign memoryWriteRequest = (stateReg == WRITE);
    assign memoryReadRequest  = (stateReg == READ);
    assign memoryXCoord       = xReg;
    assign memoryYCoord       = yReg;
    assign memoryWriteData    = colorReg;
    assign readData           = readDataReg;
    assign readDataValid      = (stateReg == RESPOND);
    assign busy               = (stateReg != IDLE);

endmodule

// File: tb/tb_draw_engine.sv
// Scoreboard bench for draw_engine: stimulus pushes expected pixel requests and read
// results; a monitor pops and compares them as the engine presents them.
module tb_draw_engine;

    localparam int LAT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [8:0] cmdX;
    logic [7:0] cmdY;
    logic [8:0] cmdWidth;
    logic [7:0] cmdHeight;
    logic [7:0] cmdColor;
    logic [7:0] readData;
    logic       readDataValid;
    logic       busy;
    logic [8:0] memoryXCoord;
    logic [7:0] memoryYCoord;
    logic       memoryWriteRequest;
    logic       memoryReadRequest;
    logic [7:0] memoryWriteData;
    logic [7:0] memoryReadData;
    logic       memoryWriteComplete;
    logic       memoryReadComplete;

    logic       respWC;
    logic       respRC;
    logic       spurWC;
    logic [7:0] readValue;

    assign memoryWriteComplete = respWC | spurWC;
    assign memoryReadComplete  = respRC;
    assign memoryReadData      = readValue;

    draw_engine dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdX(cmdX), .cmdY(cmdY), .cmdWidth(cmdWidth), .cmdHeight(cmdHeight),
        .cmdColor(cmdColor), .readData(readData), .readDataValid(readDataValid),
        .busy(busy), .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
        .memoryWriteRequest(memoryWriteRequest), .memoryReadRequest(memoryReadRequest),
        .memoryWriteData(memoryWriteData), .memoryReadData(memoryReadData),
        .memoryWriteComplete(memoryWriteComplete), .memoryReadComplete(memoryReadComplete)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit isRead;
        int x;
        int y;
        int data;
    } req_t;

    req_t reqQ[$];
    int   readQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   reqCount = 0;

    // Responder: completes LAT cycles after a request is first seen high.
    initial begin
        int cnt;
        cnt = 0;
        respWC = 1'b0;
        respRC = 1'b0;
        forever begin
            @(negedge clock);
            respWC = 1'b0;
            respRC = 1'b0;
            if (memoryWriteRequest || memoryReadRequest) begin
                cnt++;
                if (cnt == LAT) begin
                    if (memoryWriteRequest) respWC = 1'b1;
                    else                    respRC = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: new requests, held-stable requests, one-cycle gaps and read results.
    initial begin
        bit   prevReq, req, sawFall, lowBusy;
        int   lowRun;
        int   heldX, heldY, heldD;
        req_t e;
        prevReq = 0; sawFall = 0; lowBusy = 0; lowRun = 0;
        heldX = 0; heldY = 0; heldD = 0;
        forever begin
            @(negedge clock);
            req = memoryWriteRequest || memoryReadRequest;
            if (req && !prevReq) begin
                reqCount++;
                if (sawFall && lowBusy) begin
                    vectors++;
                    if (lowRun != 1) begin
                        miscompares++;
                        $display("FAIL req_gap: got %0d low cycles, want 1", lowRun);
                    end
                end
                vectors++;
                if (reqQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req: got rd=%0b (%0d,%0d) data %02h, want none",
                             memoryReadRequest, memoryXCoord, memoryYCoord, memoryWriteData);
                end else begin
                    e = reqQ.pop_front();
                    if (memoryReadRequest != e.isRead || memoryXCoord != e.x[8:0] ||
                        memoryYCoord != e.y[7:0] ||
                        (!e.isRead && memoryWriteData != e.data[7:0])) begin
                        miscompares++;
                        $display("FAIL req: got rd=%0b (%0d,%0d) data %02h, want rd=%0b (%0d,%0d) data %02h",
                                 memoryReadRequest, memoryXCoord, memoryYCoord, memoryWriteData,
                                 e.isRead, e.x, e.y, e.data);
                    end else begin
                        $display("req %s (%0d,%0d) data %02h ok", e.isRead ? "RD" : "WR",
                                 e.x, e.y, memoryWriteData);
                    end
                end
                heldX = memoryXCoord; heldY = memoryYCoord; heldD = memoryWriteData;
            end else if (req) begin
                vectors++;
                if (memoryXCoord != heldX[8:0] || memoryYCoord != heldY[7:0] ||
                    memoryWriteData != heldD[7:0]) begin
                    miscompares++;
                    $display("FAIL req_stable: got (%0d,%0d) %02h, want (%0d,%0d) %02h",
                             memoryXCoord, memoryYCoord, memoryWriteData, heldX, heldY, heldD);
                end
            end else if (prevReq) begin
                sawFall = 1; lowRun = 1; lowBusy = busy;
            end else begin
                lowRun++;
                lowBusy = lowBusy && busy;
            end
            prevReq = req;

            if (readDataValid) begin
                vectors++;
                if (readQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rdv: got readData %02h, want no pulse", readData);
                end else begin
                    int r;
                    r = readQ.pop_front();
                    if (readData != r[7:0]) begin
                        miscompares++;
                        $display("FAIL read_data: got %02h, want %02h", readData, r);
                    end else begin
                        $display("read result %02h ok", readData);
                    end
                end
            end
        end
    end

    function automatic req_t mk(bit rd, int x, int y, int d);
        req_t r;
        r.isRead = rd; r.x = x; r.y = y; r.data = d;
        return r;
    endfunction

    task automatic check(string name, bit ok, int got, int want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic sendCmd(input logic [1:0] op, input int x, input int y,
                           input int w, input int h, input int c);
        @(negedge clock);
        check("cmd_ready_before", cmdReady === 1'b1, int'(cmdReady), 1);
        cmdOp = op; cmdX = 9'(x); cmdY = 8'(y);
        cmdWidth = 9'(w); cmdHeight = 8'(h); cmdColor = 8'(c);
        cmdValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmdValid = 1'b0;
    endtask

    // Counts negedges from the first one after the accept edge until busy drops.
    task automatic waitIdle(input string name, input int expCycles);
        int n;
        n = 1;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, n == expCycles && cmdReady === 1'b1, n, expCycles);
    endtask

    task automatic issue(input string name, input logic [1:0] op, input int x, input int y,
                         input int w, input int h, input int c, input int expCycles);
        sendCmd(op, x, y, w, h, c);
        waitIdle(name, expCycles);
    endtask

    initial begin
        int base, k;
        reset = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdX = '0; cmdY = '0;
        cmdWidth = '0; cmdHeight = '0; cmdColor = '0; spurWC = 1'b0; readValue = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_ready", cmdReady === 1'b0, int'(cmdReady), 0);
        check("reset_reqs", {memoryWriteRequest, memoryReadRequest, readDataValid, busy} === 4'b0,
              int'({memoryWriteRequest, memoryReadRequest, readDataValid, busy}), 0);
        check("reset_coords", {memoryXCoord, memoryYCoord, memoryWriteData, readData} === 33'b0,
              int'({memoryXCoord, memoryYCoord}), 0);
        reset = 1'b0;

        // Single write: per-pixel cost LAT+1, plus the return to IDLE.
        reqQ.push_back(mk(0, 5, 7, 8'hA5));
        issue("single_write_cycles", 2'd0, 5, 7, 0, 0, 8'hA5, 1 * (LAT + 1) + 1);

        // 3x2 fill in raster order.
        for (int yy = 20; yy < 22; yy++)
            for (int xx = 10; xx < 13; xx++)
                reqQ.push_back(mk(0, xx, yy, 8'h3C));
        issue("fill3x2_cycles", 2'd2, 10, 20, 3, 2, 8'h3C, 6 * (LAT + 1) + 1);

        // Clipped at the bottom-right corner: only two pixels survive.
        reqQ.push_back(mk(0, 318, 239, 8'h42));
        reqQ.push_back(mk(0, 319, 239, 8'h42));
        issue("clip_fill_cycles", 2'd2, 318, 239, 4, 3, 8'h42, 2 * (LAT + 1) + 1);

        issue("full_clip_x", 2'd2, 320, 0, 2, 2, 8'h11, 1);
        issue("zero_width", 2'd2, 0, 0, 0, 5, 8'h11, 1);
        issue("reserved_op", 2'd3, 1, 1, 1, 1, 8'h11, 1);
        issue("write_clip_y", 2'd0, 4, 240, 0, 0, 8'h22, 1);

        // Reads: unclipped returns responder data, clipped returns 0 at once.
        readValue = 8'h5E;
        reqQ.push_back(mk(1, 100, 50, 0));
        readQ.push_back(8'h5E);
        issue("read_cycles", 2'd1, 100, 50, 0, 0, 0, LAT + 2);
        readQ.push_back(0);
        issue("clip_read_cycles", 2'd1, 0, 240, 0, 0, 0, 2);

        // Reset during the fourth pixel of a 4x4 fill.
        for (int xx = 0; xx < 4; xx++) reqQ.push_back(mk(0, xx, 0, 8'h77));
        base = reqCount;
        sendCmd(2'd2, 0, 0, 4, 4, 8'h77);
        k = 0;
        while (reqCount < base + 4 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("fill4x4_reach_4th", reqCount >= base + 4, reqCount - base, 4);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_reqs", {memoryWriteRequest, memoryReadRequest} === 2'b00,
              int'({memoryWriteRequest, memoryReadRequest}), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("after_reset_ready", cmdReady === 1'b1 && busy === 1'b0, int'(cmdReady), 1);
        spurWC = 1'b1;
        @(negedge clock);
        spurWC = 1'b0;
        @(negedge clock);
        check("spurious_complete", busy === 1'b0 && memoryWriteRequest === 1'b0 && cmdReady === 1'b1,
              int'(busy), 0);

        reqQ.push_back(mk(0, 1, 2, 8'h99));
        issue("post_reset_write", 2'd0, 1, 2, 0, 0, 8'h99, LAT + 2);

        repeat (5) @(negedge clock);
        check("req_queue_empty", reqQ.size() == 0, reqQ.size(), 0);
        check("read_queue_empty", readQ.size() == 0, readQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/draw_engine.md
# draw_engine

Host-side initiator for the frame-buffer memory request interface. Accepts single-pixel write, single-pixel read and rectangle-fill commands from the host/CPU bridge. Turns each command into a sequence of one-pixel requests on the memoryX/Y/Read/Write handshake. Sits between the command decoder and the SRAM memory manager, which responds with one-cycle completion pulses.

## Interface
- SCREEN_WIDTH, 320, visible columns; x coordinates ≥ this are clipped.
- SCREEN_HEIGHT, 240, visible rows; y coordinates ≥ this are clipped.

- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmdValid  in  1  host command present.
- cmdReady  out  1  engine can accept a command this cycle.
- cmdOp  in  2  0 = write pixel, 1 = read pixel, 2 = fill rect, 3 = reserved.
- cmdX  in  9  start column.
- cmdY  in  8  start row.
- cmdWidth  in  9  fill width in pixels (op 2 only).
- cmdHeight  in  8  fill height in pixels (op 2 only).
- cmdColor  in  8  pixel value (ops 0, 2).
- readData  out  8  result of the last read.
- readDataValid  out  1  one-cycle pulse; readData is valid.
- busy  out  1  a command is in progress.
- memoryXCoord  out  9  request column.
- memoryYCoord  out  8  request row.
- memoryWriteRequest  out  1  level write request.
- memoryReadRequest  out  1  level read request.
- memoryWriteData  out  8  write value.
- memoryReadData  in  8  read value, valid with memoryReadComplete.
- memoryWriteComplete  in  1  one-cycle write-done pulse.
- memoryReadComplete  in  1  one-cycle read-done pulse.

## Operation
- States: IDLE, WRITE, READ, STEP, RESPOND.
- cmdReady = (state == IDLE) && !reset.
- A command is accepted on a posedge where cmdValid && cmdReady.

**On accept, clipping is computed and all command fields are latched:**
- If cmdX ≥ SCREEN_WIDTH or cmdY ≥ SCREEN_HEIGHT, the command is fully clipped.
- Otherwise, effective width = min(cmdWidth, SCREEN_WIDTH − cmdX) and effective height = min(cmdHeight, SCREEN_HEIGHT − cmdY).
- Ops 0 and 1 use width = height = 1.

**Next state after accept:**
- Op 0/2 with nonzero effective size → WRITE.
- Op 1 unclipped → READ.
- Op 1 clipped → RESPOND with readData = 0.
- Op 3, or op 0/2 with zero effective size → IDLE. No memory request is issued.

**Request and completion handling:**
- WRITE: memoryWriteRequest = 1; coords and data are registered and held stable until complete. When memoryWriteComplete is sampled high, go to STEP.
- READ: memoryReadRequest = 1. When memoryReadComplete is sampled high, capture memoryReadData into readData and go to RESPOND.
- RESPOND: readDataValid = 1 for exactly one cycle, then IDLE.

**STEP (one cycle, both requests low) advances in raster order:**
- If x + 1 < x0 + effective width: x = x + 1.
- Else x = x0 and y = y + 1.
- If the last pixel is done → IDLE, else → WRITE.

**Other behaviour:**
- Completion pulses that do not match the current state, or that arrive in IDLE/STEP, are ignored.
- busy = (state != IDLE).
- Coordinate arithmetic is unsigned. Clip sums are computed in 10-bit (x) and 9-bit (y) to avoid wrap.

**Reset values:**
- state IDLE.
- memoryWriteRequest and memoryReadRequest 0.
- memoryXCoord, memoryYCoord, memoryWriteData 0.
- readData 0; readDataValid 0.
- cmdReady 0 while reset is high.

**Reset mid-operation:** requests drop on the reset edge. The command is discarded and no readDataValid pulse is produced.

## Timing
- Accept edge N → request high from cycle N+1, with coords and data valid in the same cycle.
- Complete sampled at edge M → request low from cycle M+1.
  - Each request is low for exactly one cycle (STEP) before the next pixel's request.
  - This satisfies the responder's requirement that a request drop after completion and is re-sampled fresh.
- Per-pixel cost = responder latency + 1 cycle.
- Read: complete sampled at edge M → readDataValid high during cycle M+1; cmdReady high in cycle M+2.
- Last write complete sampled at edge M → STEP in cycle M+1 → cmdReady high in cycle M+2.
- Clipped read: readDataValid high in cycle N+1.
- Zero-size or reserved command: cmdReady high again in cycle N+1.

## Test plan
- **Single write.** Op 0 at (5,7), color 0xA5; responder completes 3 cycles after request → exactly one write request at (5,7), data 0xA5; busy drops 2 cycles after complete.
- **Fill 3×2.** Op 2 at (10,20), color 0x3C → writes at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21) in that order, each data 0x3C. Request is low exactly one cycle between pixels.
- **Clipped fill.** Op 2 at (318,239), width 4, height 3 → only (318,239) and (319,239) are written.
- **Fully clipped.** Op 2 at (320,0), and a separate op 2 with width 0 → no requests; cmdReady returns the next cycle.
- **Read.** Op 1 at (100,50); responder returns 0x5E → readData = 0x5E with a one-cycle readDataValid; clipped read at (0,240) → readData 0, pulse the next cycle.
- **Reset mid-fill.** Reset asserted during the fourth pixel of a 4×4 fill → requests low the next cycle, no further requests, cmdReady high once reset deasserts; a spurious memoryWriteComplete in IDLE causes no state change.
